dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 12, dmem word-address width.
REQ-002 Parameter: DATA_W, 32, dmem data width.
REQ-003 Parameter: LOCK_MAX, 16, maximum consecutive locked grants to port 1 (range 1..255).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; no other clock or reset input exists.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 p0_req, p0_wren  in  1 each  processor access request; 1 = write, 0 = read.
REQ-008 p0_addr  in  ADDR_W  processor address; p0_data  in  DATA_W  processor write data.
REQ-009 p0_gnt  out  1  processor access issued this cycle; p0_rvalid  out  1  processor read data valid; p0_q  out  DATA_W  read data.
REQ-010 p1_req, p1_wren, p1_lock  in  1 each  loader/debug port request, write flag, and burst-hold request.
REQ-011 p1_addr  in  ADDR_W; p1_data  in  DATA_W; p1_gnt, p1_rvalid  out  1; p1_q  out  DATA_W  (same meanings as port 0).
REQ-012 mem_address  out  ADDR_W; mem_data  out  DATA_W; mem_wren  out  1; mem_q  in  DATA_W  single-port synchronous dmem, read data valid one cycle after address.

Function
REQ-013 FSM states: IDLE, OWN0, OWN1, LOCK1; state is the owner of the issue slot in the current cycle.
REQ-014 At most one access is issued per cycle; pN_gnt is combinational, asserted in the cycle the access is driven on mem_*.
REQ-015 Requester holds req, wren, addr, data stable until it sees gnt high; gnt never asserts without req.
REQ-016 Only one requesting: that requester is granted the same cycle (zero wait).
REQ-017 Both requesting, not in LOCK1: round-robin; grant the port not granted last; register last_grant updates on every grant.
REQ-018 Granted port drives mem_address/mem_data; mem_wren = granted port's wren AND its gnt; with no grant, mem_wren = 0 and mem_address/mem_data hold the last issued values.
REQ-019 p1 granted with p1_lock = 1: next state LOCK1; in LOCK1 p1 wins regardless of p0_req while p1_req and p1_lock stay high.
REQ-020 Lock counter (8 bits) counts consecutive LOCK1 grants; on reaching LOCK_MAX, next cycle SHALL go to OWN0 if p0_req, forcing release; counter clears on leaving LOCK1.
REQ-021 LOCK1 exits to IDLE/OWN0 when p1_req or p1_lock drops; no grant is lost or duplicated at the exit cycle.
REQ-022 pN_rvalid is registered: high exactly one cycle after a read grant to port N, low after write grants; pN_q = mem_q, valid only when pN_rvalid.
REQ-023 Back-to-back reads from alternating ports: each rvalid goes to the issuing port only; tag register records the port of the previous-cycle read.
REQ-024 No address wrap or address translation; addresses pass through unchanged.

Reset
REQ-025 While reset is high on a clock edge: state = IDLE, last_grant = port 1 (so port 0 wins first contention), lock counter = 0, rvalid tag cleared.
REQ-026 During and one cycle after reset: p0_gnt, p1_gnt, mem_wren, p0_rvalid, p1_rvalid = 0; mem_address, mem_data = 0.
REQ-027 Reset asserted mid-read: the pending rvalid SHALL NOT assert; the in-flight read is discarded.

Verification
REQ-028 Single read: p0 read addr 0x010, dmem[0x010] = 0xDEADBEEF -> p0_gnt same cycle, p0_rvalid next cycle, p0_q = 0xDEADBEEF, p1 outputs idle.
REQ-029 Contention after reset: p0 and p1 both reading for 4 cycles -> grants p0, p1, p0, p1; each rvalid goes to the correct port, one cycle later.
REQ-030 Write then read: p1 write 0x00000055 to 0x3FF, then p0 read 0x3FF -> mem_wren high for 1 cycle only, p0_q = 0x00000055.
REQ-031 Lock limit: LOCK_MAX = 4, p1_lock held with continuous p1_req and p0_req -> p1 granted 4 consecutive locked cycles, then p0 granted.
REQ-032 Reset mid-read: p0 read granted, reset high next edge -> p0_rvalid stays 0, all outputs 0, first contention after reset goes to p0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles everything the data-memory arbiter talks to except clock and
//   reset. This covers the processor port (p0_*), the loader/debug port
//   (p1_*) and the single-port synchronous dmem (mem_*).
//
//   Port 0 : p0_req, p0_wren, p0_addr, p0_data -> arbiter
//            p0_gnt, p0_rvalid, p0_q           <- arbiter
//   Port 1 : p1_req, p1_wren, p1_lock, p1_addr, p1_data -> arbiter
//            p1_gnt, p1_rvalid, p1_q                    <- arbiter
//   Memory : mem_address, mem_data, mem_wren <- arbiter
//            mem_q (valid one cycle after its address) -> arbiter
//
//   The arbiter uses the slave modport. Requesters and the memory model
//   use the master modport.

interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_wren;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_data;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_q;

    logic              p1_req;
    logic              p1_wren;
    logic              p1_lock;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_data;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_q;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  p0_req, p0_wren, p0_addr, p0_data,
        output p0_gnt, p0_rvalid, p0_q,
        input  p1_req, p1_wren, p1_lock, p1_addr, p1_data,
        output p1_gnt, p1_rvalid, p1_q,
        output mem_address, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output p0_req, p0_wren, p0_addr, p0_data,
        input  p0_gnt, p0_rvalid, p0_q,
        output p1_req, p1_wren, p1_lock, p1_addr, p1_data,
        input  p1_gnt, p1_rvalid, p1_q,
        input  mem_address, mem_data, mem_wren,
        output mem_q
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter in front of a single-port synchronous data memory.
//   It issues at most one access per cycle. Grants are combinational, so a
//   requester that is alone wins in the same cycle. When both ports contend,
//   they alternate round-robin. Port 1 can hold the slot with p1_lock for
//   up to LOCK_MAX consecutive grants. After that limit, a waiting port 0
//   gets the slot. Read data comes back one cycle after the grant and is
//   steered to the port that issued the read.
//
//   Ports:
//     clock : single clock, rising edge
//     reset : synchronous, active-high
//     bus   : dmem_arbiter_if.slave (p0_*, p1_*, mem_* signals)
//
//   Parameters:
//     ADDR_W   : dmem word-address width
//     DATA_W   : dmem data width
//     LOCK_MAX : maximum consecutive locked grants to port 1 (1..255)

module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN0  = 2'd1;
    localparam logic [1:0] OWN1  = 2'd2;
    localparam logic [1:0] LOCK1 = 2'd3;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;   // 1 = port 1 won last
    logic [7:0]        lock_cnt_q,   lock_cnt_d;
    logic              rd_vld_q,     rd_vld_d;
    logic              rd_tag_q,     rd_tag_d;       // port of the pending read
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic              blank_q;                      // first cycle after reset

    logic issue_en;
    logic locked;
    logic gnt0;
    logic gnt1;

    // Grant selection
    always_comb begin
        issue_en = !reset && !blank_q;
        locked   = (state_q == LOCK1) && bus.p1_req && bus.p1_lock;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (issue_en) begin
            if (locked) begin
                // Once the lock budget is spent, a waiting port 0 takes the slot
                if ((lock_cnt_q >= LOCK_LIMIT) && bus.p0_req) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (bus.p0_req && bus.p1_req) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = bus.p0_req;
                gnt1 = bus.p1_req;
            end
        end
    end

    // Next-state: owner, round-robin history, lock budget, read tag, held bus
    always_comb begin
        state_d      = IDLE;
        last_grant_d = last_grant_q;
        lock_cnt_d   = '0;
        rd_vld_d     = 1'b0;
        rd_tag_d     = rd_tag_q;
        addr_d       = addr_q;
        data_d       = data_q;
        if (gnt0) begin
            state_d      = OWN0;
            last_grant_d = 1'b0;
            rd_vld_d     = !bus.p0_wren;
            rd_tag_d     = 1'b0;
            addr_d       = bus.p0_addr;
            data_d       = bus.p0_data;
        end else if (gnt1) begin
            state_d      = bus.p1_lock ? LOCK1 : OWN1;
            last_grant_d = 1'b1;
            rd_vld_d     = !bus.p1_wren;
            rd_tag_d     = 1'b1;
            addr_d       = bus.p1_addr;
            data_d       = bus.p1_data;
            // The counter is cleared outside LOCK1, so entering the lock starts at 1
            if (bus.p1_lock) begin
                lock_cnt_d = (lock_cnt_q < LOCK_LIMIT) ? lock_cnt_q + 8'd1 : lock_cnt_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lock_cnt_q   <= '0;
            rd_vld_q     <= 1'b0;
            rd_tag_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            blank_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_vld_q     <= rd_vld_d;
            rd_tag_q     <= rd_tag_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            blank_q      <= 1'b0;
        end
    end

    // The memory bus shows the granted access, or the last issued one when idle
    assign bus.mem_address = addr_d;
    assign bus.mem_data    = data_d;
    assign bus.mem_wren    = (gnt0 && bus.p0_wren) || (gnt1 && bus.p1_wren);

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.p0_rvalid = rd_vld_q && !rd_tag_q;
    assign bus.p1_rvalid = rd_vld_q && rd_tag_q;
    assign bus.p0_q      = bus.mem_q;
    assign bus.p1_q      = bus.mem_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed stimulus for dmem_arbiter (LOCK_MAX = 4) with a behavioural
//   synchronous dmem. Expected grants and read returns are queued as each
//   vector is issued and popped by a negedge monitor.

module tb_dmem_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .LOCK_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        port;
        int          cyc;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
    } gnt_t;

    typedef struct {
        logic        port;
        int          cyc;
        logic [31:0] data;
    } rd_t;

    gnt_t gq[$];
    rd_t  rq[$];

    logic [31:0] mem [0:4095];

    // Synchronous single-port memory: low 128 words hold 0xA5A5A000 | addr
    initial begin
        for (int unsigned i = 0; i < 4096; i++) begin
            mem[i] = (i < 128) ? (32'hA5A5A000 | 32'(i)) : 32'h0;
        end
        mem[12'h010] = 32'hDEADBEEF;
        bus.mem_q = '0;
        forever begin
            @(posedge clock);
            if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
            bus.mem_q <= mem[bus.mem_address];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({bus.p0_gnt, bus.p1_gnt, bus.mem_wren, bus.p0_rvalid, bus.p1_rvalid,
                    bus.mem_address, bus.mem_data});
    endfunction

    task automatic drive(input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1, input logic [11:0] a1,
                         input logic [31:0] d1);
        bus.p0_req  = r0; bus.p0_wren = w0; bus.p0_addr = a0; bus.p0_data = d0;
        bus.p1_req  = r1; bus.p1_wren = w1; bus.p1_lock = l1; bus.p1_addr = a1; bus.p1_data = d1;
    endtask

    task automatic push_gnt(input logic port, input logic wr, input logic [11:0] a, input logic [31:0] d);
        gnt_t e;
        e.port = port; e.cyc = cyc; e.wr = wr; e.addr = a; e.data = d;
        gq.push_back(e);
    endtask

    task automatic push_rd(input logic port, input logic [31:0] d);
        rd_t e;
        e.port = port; e.cyc = cyc + 1; e.data = d;
        rq.push_back(e);
    endtask

    // g: 0 = no grant expected, 1 = port 0, 2 = port 1; rd = expected read data
    task automatic vec(input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1, input logic [11:0] a1,
                       input logic [31:0] d1, input int g, input logic [31:0] rd);
        drive(r0, w0, a0, d0, r1, w1, l1, a1, d1);
        if (g == 1) begin
            push_gnt(1'b0, w0, a0, d0);
            if (!w0) push_rd(1'b0, rd);
        end else if (g == 2) begin
            push_gnt(1'b1, w1, a1, d1);
            if (!w1) push_rd(1'b1, rd);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor
    always @(negedge clock) begin
        gnt_t ge;
        rd_t  re;
        if (bus.mem_wren) chk("wren_has_gnt", 64'(bus.p0_gnt | bus.p1_gnt), 64'(1));
        if (bus.p0_gnt || bus.p1_gnt) begin
            chk("one_gnt", 64'(bus.p0_gnt & bus.p1_gnt), 64'(0));
            if (gq.size() == 0) begin
                chk("gnt_expected", 64'(gq.size()), 64'(1));
            end else begin
                ge = gq.pop_front();
                chk("gnt_port", 64'(bus.p1_gnt), 64'(ge.port));
                chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
                chk("mem_address", 64'(bus.mem_address), 64'(ge.addr));
                chk("mem_wren", 64'(bus.mem_wren), 64'(ge.wr));
                if (ge.wr) chk("mem_data", 64'(bus.mem_data), 64'(ge.data));
            end
        end
        if (bus.p0_rvalid || bus.p1_rvalid) begin
            chk("one_rvalid", 64'(bus.p0_rvalid & bus.p1_rvalid), 64'(0));
            if (rq.size() == 0) begin
                chk("rvalid_expected", 64'(rq.size()), 64'(1));
            end else begin
                re = rq.pop_front();
                chk("rd_port", 64'(bus.p1_rvalid), 64'(re.port));
                chk("rd_cycle", 64'(cyc), 64'(re.cyc));
                chk("rd_data", 64'(bus.p1_rvalid ? bus.p1_q : bus.p0_q), 64'(re.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        // Reset with both ports already requesting
        reset = 1'b1;
        drive(1, 0, 12'h020, '0, 1, 0, 0, 12'h021, '0);
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock); chk("reset_outputs", outs_vec(), 64'(0));
        step();
        reset = 1'b0;
        @(negedge clock); chk("post_reset_outputs", outs_vec(), 64'(0));
        step();

        // Contention straight after reset: p0, p1, p0, p1, then p0 alone
        vec(1, 0, 12'h020, '0, 1, 0, 0, 12'h021, '0, 1, 32'hA5A5A020); step();
        vec(1, 0, 12'h022, '0, 1, 0, 0, 12'h021, '0, 2, 32'hA5A5A021); step();
        vec(1, 0, 12'h022, '0, 1, 0, 0, 12'h023, '0, 1, 32'hA5A5A022); step();
        vec(1, 0, 12'h024, '0, 1, 0, 0, 12'h023, '0, 2, 32'hA5A5A023); step();
        vec(1, 0, 12'h024, '0, 0, 0, 0, 12'h000, '0, 1, 32'hA5A5A024); step();

        // Single read
        vec(1, 0, 12'h010, '0, 0, 0, 0, 12'h000, '0, 1, 32'hDEADBEEF); step();

        // Idle: bus holds last issued address, no write strobe
        vec(0, 0, 12'h000, '0, 0, 0, 0, 12'h000, '0, 0, '0);
        @(negedge clock); chk("idle_bus_hold", 64'({bus.mem_wren, bus.mem_address}), 64'({1'b0, 12'h010}));
        step();

        // Write then read back
        vec(0, 0, 12'h000, '0, 1, 1, 0, 12'h3FF, 32'h00000055, 2, '0); step();
        vec(1, 0, 12'h3FF, '0, 0, 0, 0, 12'h000, '0, 1, 32'h00000055); step();

        // Lock: four locked p1 grants, then p0 is forced in
        vec(1, 0, 12'h030, '0, 1, 0, 1, 12'h040, '0, 2, 32'hA5A5A040); step();
        vec(1, 0, 12'h030, '0, 1, 0, 1, 12'h041, '0, 2, 32'hA5A5A041); step();
        vec(1, 0, 12'h030, '0, 1, 0, 1, 12'h042, '0, 2, 32'hA5A5A042); step();
        vec(1, 0, 12'h030, '0, 1, 0, 1, 12'h043, '0, 2, 32'hA5A5A043); step();
        vec(1, 0, 12'h030, '0, 1, 0, 1, 12'h044, '0, 1, 32'hA5A5A030); step();
        vec(0, 0, 12'h000, '0, 1, 0, 1, 12'h044, '0, 2, 32'hA5A5A044); step();
        // Lock dropped while in LOCK1: round-robin resumes
        vec(1, 0, 12'h031, '0, 1, 0, 0, 12'h045, '0, 1, 32'hA5A5A031); step();
        vec(0, 0, 12'h000, '0, 1, 0, 0, 12'h045, '0, 2, 32'hA5A5A045); step();
        // Request dropped while in LOCK1
        vec(0, 0, 12'h000, '0, 1, 0, 1, 12'h046, '0, 2, 32'hA5A5A046); step();
        vec(1, 0, 12'h032, '0, 0, 0, 0, 12'h000, '0, 1, 32'hA5A5A032); step();

        // Reset lands on the edge that would have returned a p0 read
        drive(1, 0, 12'h011, '0, 0, 0, 0, 12'h000, '0);
        push_gnt(1'b0, 1'b0, 12'h011, '0);
        @(negedge clock); #1;
        reset = 1'b1;
        drive(0, 0, 12'h000, '0, 0, 0, 0, 12'h000, '0);
        step();
        @(negedge clock); chk("mid_read_reset_outputs", outs_vec(), 64'(0));
        step();
        reset = 1'b0;
        drive(1, 0, 12'h012, '0, 1, 0, 0, 12'h013, '0);
        @(negedge clock); chk("mid_read_post_reset_gnt", 64'({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid}), 64'(0));
        step();
        vec(1, 0, 12'h012, '0, 1, 0, 0, 12'h013, '0, 1, 32'hA5A5A012); step();
        vec(0, 0, 12'h000, '0, 1, 0, 0, 12'h013, '0, 2, 32'hA5A5A013); step();
        vec(0, 0, 12'h000, '0, 0, 0, 0, 12'h000, '0, 0, '0); step();
        step();

        chk("gnt_queue_drained", 64'(gq.size()), 64'(0));
        chk("rd_queue_drained", 64'(rq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
